// File: rtl/data_cache_if.sv
// Pipeline-side request/response and backing-memory signals of the data cache.
// The cache uses the slave view; the pipeline/memory side uses the master view.
interface data_cache_if #(
    parameter int LINE_WORDS = 4
);
    // pipeline request / response
    logic                         is_input_valid;
    logic [31:0]                  addr;
    logic                         mem_read;
    logic                         mem_write;
    logic [31:0]                  din;
    logic                         is_ready;
    logic                         is_output_valid;
    logic [31:0]                  dout;
    logic                         is_hit;
    // backing memory, whole-line transfers
    logic                         mem_req;
    logic                         mem_we;
    logic [31:0]                  mem_addr;
    logic [LINE_WORDS-1:0][31:0]  mem_wdata;
    logic                         mem_gnt;
    logic                         mem_rvalid;
    logic [LINE_WORDS-1:0][31:0]  mem_rdata;

    modport slave (
        input  is_input_valid, addr, mem_read, mem_write, din,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output is_ready, is_output_valid, dout, is_hit,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output is_input_valid, addr, mem_read, mem_write, din,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  is_ready, is_output_valid, dout, is_hit,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache. One request in flight;
// misses evict a dirty victim, refill the line, then replay the lookup.
module data_cache #(
    parameter int NUM_SETS   = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic         clk,
    input  logic         reset,
    data_cache_if.slave  bus
);
    localparam int WOFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int OFF_W  = WOFF_W + 2;
    localparam int TAG_W  = 32 - IDX_W - OFF_W;

    typedef logic [LINE_WORDS-1:0][31:0] line_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE,
        S_WAIT_FILL
    } state_t;

    state_t state_q, state_d;
    logic   first_try_q, first_try_d;
    logic   rdy_q;

    // latched request
    logic [31:0] addr_q;
    logic [31:0] din_q;
    logic        wr_q;

    // line state; tag/data have no reset, valid gates them
    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    line_t               data_q [NUM_SETS];

    // registered memory-side outputs so mem_req never glitches
    logic        mem_req_q,   mem_req_d;
    logic        mem_we_q,    mem_we_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    line_t       mem_wdata_q, mem_wdata_d;

    logic [WOFF_W-1:0] req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              hit;
    logic              resp;
    logic              accept;
    logic              unused_byte_off;

    assign req_off = addr_q[OFF_W-1:2];
    assign req_idx = addr_q[OFF_W+IDX_W-1:OFF_W];
    assign req_tag = addr_q[31:OFF_W+IDX_W];
    assign unused_byte_off = ^addr_q[1:0];

    assign hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign resp   = (state_q == S_COMPARE) && hit;
    assign accept = bus.is_input_valid && bus.is_ready && (bus.mem_read || bus.mem_write);

    // ready is held low until the first edge after reset release
    assign bus.is_ready        = rdy_q && (state_q == S_IDLE);
    assign bus.is_output_valid = resp;
    assign bus.is_hit          = resp && first_try_q;
    assign bus.dout            = (resp && !wr_q) ? data_q[req_idx][req_off] : 32'h0;
    assign bus.mem_req         = mem_req_q;
    assign bus.mem_we          = mem_we_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_wdata       = mem_wdata_q;

    // next-state: lookup, eviction, refill sequencing
    always_comb begin
        state_d     = state_q;
        first_try_d = first_try_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d     = S_COMPARE;
                    first_try_d = 1'b1;
                end
            end
            S_COMPARE: begin
                if (hit) begin
                    state_d = S_IDLE;
                end else begin
                    first_try_d = 1'b0;
                    state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? S_WRITEBACK : S_ALLOCATE;
                end
            end
            S_WRITEBACK: if (bus.mem_gnt)    state_d = S_ALLOCATE;
            S_ALLOCATE:  if (bus.mem_gnt)    state_d = S_WAIT_FILL;
            S_WAIT_FILL: if (bus.mem_rvalid) state_d = S_COMPARE;
            default:     state_d = S_IDLE;
        endcase
    end

    // memory request contents for the state being entered
    always_comb begin
        mem_req_d   = (state_d == S_WRITEBACK) || (state_d == S_ALLOCATE);
        mem_we_d    = (state_d == S_WRITEBACK);
        mem_addr_d  = 32'h0;
        mem_wdata_d = '0;
        if (state_d == S_WRITEBACK) begin
            mem_addr_d  = {tag_q[req_idx], req_idx, {OFF_W{1'b0}}};
            mem_wdata_d = data_q[req_idx];
        end else if (state_d == S_ALLOCATE) begin
            mem_addr_d  = {req_tag, req_idx, {OFF_W{1'b0}}};
        end
    end

    // control state, request latch and memory-side output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            first_try_q <= 1'b0;
            rdy_q       <= 1'b0;
            addr_q      <= 32'h0;
            din_q       <= 32'h0;
            wr_q        <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            first_try_q <= first_try_d;
            rdy_q       <= 1'b1;
            if (accept) begin
                addr_q <= bus.addr;
                din_q  <= bus.din;
                wr_q   <= bus.mem_write;
            end
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // valid/dirty bits: set on refill, dirty on store hit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (state_q == S_WAIT_FILL && bus.mem_rvalid) begin
            valid_q[req_idx] <= 1'b1;
            dirty_q[req_idx] <= 1'b0;
        end else if (resp && wr_q) begin
            dirty_q[req_idx] <= 1'b1;
        end
    end

    // tag/data arrays: refill writes the whole line, store hit merges one word
    always_ff @(posedge clk) begin
        if (state_q == S_WAIT_FILL && bus.mem_rvalid) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= bus.mem_rdata;
        end else if (resp && wr_q) begin
            data_q[req_idx][req_off] <= din_q;
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: cold miss, hits, store hit, dirty eviction,
// delayed grant, store-miss allocate and asynchronous reset mid-operation.
module tb_data_cache;
    typedef logic [3:0][31:0] line_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    data_cache_if #(.LINE_WORDS(4)) bus ();

    data_cache #(.NUM_SETS(16), .LINE_WORDS(4)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    // present one request for a single acceptance edge
    task automatic send(input logic [31:0] a, input logic wr, input logic [31:0] d);
        @(negedge clk);
        bus.is_input_valid = 1'b1;
        bus.addr      = a;
        bus.mem_read  = !wr;
        bus.mem_write = wr;
        bus.din       = d;
        @(posedge clk);
        #1;
        bus.is_input_valid = 1'b0;
    endtask

    // wait for the response pulse, noting any memory request seen on the way
    task automatic wait_resp(output logic got, output logic [31:0] d, output logic hit,
                             output int cyc, output logic sawreq);
        got = 1'b0; d = 32'h0; hit = 1'b0; cyc = 0; sawreq = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (bus.mem_req) sawreq = 1'b1;
            if (bus.is_output_valid) begin
                got = 1'b1; d = bus.dout; hit = bus.is_hit; cyc = i;
                break;
            end
        end
    endtask

    // wait for a memory request, capture it, grant it for one cycle
    task automatic wait_mem(output logic got, output logic we, output logic [31:0] a,
                            output line_t wd);
        got = 1'b0; we = 1'b0; a = 32'h0; wd = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                got = 1'b1; we = bus.mem_we; a = bus.mem_addr; wd = bus.mem_wdata;
                bus.mem_gnt = 1'b1;
                @(posedge clk);
                #1;
                bus.mem_gnt = 1'b0;
                break;
            end
        end
    endtask

    task automatic give_fill(input line_t r);
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = r;
        @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.is_ready, bus.is_output_valid, bus.is_hit, bus.mem_req, bus.mem_we} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got rdy/ov/hit/req/we=%b exp=00000",
                     {bus.is_ready, bus.is_output_valid, bus.is_hit, bus.mem_req, bus.mem_we});
        end
        checks++;
        if (bus.dout !== 32'h0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_buses dout=%h mem_addr=%h wdata=%h exp all 0",
                     bus.dout, bus.mem_addr, bus.mem_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.is_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset got=%b exp=1", bus.is_ready);
        end
    endtask

    task automatic test_cold_load();
        logic got, we, hit, sawreq; logic [31:0] a, d; line_t wd; int cyc;
        send(32'h10, 1'b0, 32'h0);
        wait_mem(got, we, a, wd);
        checks++;
        if (got !== 1'b1 || we !== 1'b0 || a !== 32'h10) begin
            failures++;
            $display("FAIL cold_fetch got=%b we=%b addr=%h exp 1/0/00000010", got, we, a);
        end
        give_fill({32'h44, 32'h33, 32'h22, 32'h11});
        wait_resp(got, d, hit, cyc, sawreq);
        checks++;
        if (got !== 1'b1 || d !== 32'h11 || hit !== 1'b0) begin
            failures++;
            $display("FAIL cold_resp got=%b dout=%h hit=%b exp 1/00000011/0", got, d, hit);
        end
        @(negedge clk);
        checks++;
        if (bus.is_output_valid !== 1'b0) begin
            failures++;
            $display("FAIL resp_one_cycle ov=%b exp=0", bus.is_output_valid);
        end
        send(32'h14, 1'b0, 32'h0);
        wait_resp(got, d, hit, cyc, sawreq);
        checks++;
        if (got !== 1'b1 || d !== 32'h22 || hit !== 1'b1 || cyc != 1 || sawreq !== 1'b0) begin
            failures++;
            $display("FAIL load_hit dout=%h hit=%b cyc=%0d req=%b exp 00000022/1/1/0", d, hit, cyc, sawreq);
        end
    endtask

    task automatic test_store_hit();
        logic got, hit, sawreq; logic [31:0] d; int cyc;
        send(32'h14, 1'b1, 32'hDEADBEEF);
        wait_resp(got, d, hit, cyc, sawreq);
        checks++;
        if (got !== 1'b1 || hit !== 1'b1 || d !== 32'h0 || sawreq !== 1'b0 || cyc != 1) begin
            failures++;
            $display("FAIL store_hit got=%b hit=%b dout=%h req=%b cyc=%0d exp 1/1/0/0/1", got, hit, d, sawreq, cyc);
        end
        send(32'h14, 1'b0, 32'h0);
        wait_resp(got, d, hit, cyc, sawreq);
        checks++;
        if (d !== 32'hDEADBEEF || hit !== 1'b1) begin
            failures++;
            $display("FAIL store_readback dout=%h hit=%b exp deadbeef/1", d, hit);
        end
    endtask

    task automatic test_dirty_evict();
        logic got, we, hit, sawreq; logic [31:0] a, d; line_t wd; int cyc;
        send(32'h114, 1'b0, 32'h0);
        wait_mem(got, we, a, wd);
        checks++;
        if (got !== 1'b1 || we !== 1'b1 || a !== 32'h10 ||
            wd !== {32'h44, 32'h33, 32'hDEADBEEF, 32'h11}) begin
            failures++;
            $display("FAIL evict_wb we=%b addr=%h wdata=%h exp 1/00000010/00000044_00000033_deadbeef_00000011",
                     we, a, wd);
        end
        wait_mem(got, we, a, wd);
        checks++;
        if (got !== 1'b1 || we !== 1'b0 || a !== 32'h110) begin
            failures++;
            $display("FAIL evict_fetch got=%b we=%b addr=%h exp 1/0/00000110", got, we, a);
        end
        give_fill({32'hA4, 32'hA3, 32'hA2, 32'hA1});
        wait_resp(got, d, hit, cyc, sawreq);
        checks++;
        if (got !== 1'b1 || d !== 32'hA2 || hit !== 1'b0) begin
            failures++;
            $display("FAIL evict_resp dout=%h hit=%b exp 000000a2/0", d, hit);
        end
    endtask

    task automatic test_delayed_grant();
        logic got, hit, sawreq, we0; logic [31:0] d, a0; int cyc, unstable;
        send(32'h310, 1'b0, 32'h0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_req) begin got = 1'b1; break; end
        end
        a0 = bus.mem_addr; we0 = bus.mem_we; unstable = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== a0 || bus.mem_we !== we0 ||
                bus.is_output_valid !== 1'b0) unstable++;
        end
        checks++;
        if (got !== 1'b1 || a0 !== 32'h310 || we0 !== 1'b0) begin
            failures++;
            $display("FAIL delay_req got=%b addr=%h we=%b exp 1/00000310/0", got, a0, we0);
        end
        checks++;
        if (unstable != 0) begin
            failures++;
            $display("FAIL delay_stable unstable_cycles=%0d exp 0", unstable);
        end
        bus.mem_gnt = 1'b1;
        @(posedge clk);
        #1 bus.mem_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL req_drop_after_gnt req=%b exp 0", bus.mem_req);
        end
        give_fill({32'hB3, 32'hB2, 32'hB1, 32'hB0});
        wait_resp(got, d, hit, cyc, sawreq);
        checks++;
        if (got !== 1'b1 || d !== 32'hB0 || hit !== 1'b0) begin
            failures++;
            $display("FAIL delay_resp dout=%h hit=%b exp 000000b0/0", d, hit);
        end
    endtask

    task automatic test_store_miss();
        logic got, we, hit, sawreq; logic [31:0] a, d; line_t wd; int cyc;
        send(32'h208, 1'b1, 32'hCAFE);
        wait_mem(got, we, a, wd);
        checks++;
        if (got !== 1'b1 || we !== 1'b0 || a !== 32'h200) begin
            failures++;
            $display("FAIL smiss_fetch got=%b we=%b addr=%h exp 1/0/00000200", got, we, a);
        end
        give_fill({32'hD3, 32'hD2, 32'hD1, 32'hD0});
        wait_resp(got, d, hit, cyc, sawreq);
        checks++;
        if (got !== 1'b1 || hit !== 1'b0 || d !== 32'h0) begin
            failures++;
            $display("FAIL smiss_resp got=%b hit=%b dout=%h exp 1/0/0", got, hit, d);
        end
        send(32'h208, 1'b0, 32'h0);
        wait_resp(got, d, hit, cyc, sawreq);
        checks++;
        if (d !== 32'hCAFE || hit !== 1'b1) begin
            failures++;
            $display("FAIL smiss_readback dout=%h hit=%b exp 0000cafe/1", d, hit);
        end
        send(32'h008, 1'b0, 32'h0);
        wait_mem(got, we, a, wd);
        checks++;
        if (got !== 1'b1 || we !== 1'b1 || a !== 32'h200 ||
            wd !== {32'hD3, 32'hCAFE, 32'hD1, 32'hD0}) begin
            failures++;
            $display("FAIL smiss_wb we=%b addr=%h wdata=%h exp 1/00000200/000000d3_0000cafe_000000d1_000000d0",
                     we, a, wd);
        end
        wait_mem(got, we, a, wd);
        give_fill({32'hE3, 32'hE2, 32'hE1, 32'hE0});
        wait_resp(got, d, hit, cyc, sawreq);
        checks++;
        if (a !== 32'h0 || d !== 32'hE2 || hit !== 1'b0) begin
            failures++;
            $display("FAIL smiss_refetch addr=%h dout=%h hit=%b exp 00000000/000000e2/0", a, d, hit);
        end
    endtask

    task automatic test_reset_mid_op();
        logic got, we, hit, sawreq; logic [31:0] a, d; line_t wd; int cyc;
        // reset while a fetch request is on the bus
        send(32'h510, 1'b0, 32'h0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_req) begin got = 1'b1; break; end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (got !== 1'b1 || bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL async_reset_req seen=%b req=%b addr=%h exp 1/0/0", got, bus.mem_req, bus.mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // reset while waiting for fill data
        send(32'h410, 1'b0, 32'h0);
        wait_mem(got, we, a, wd);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.is_ready, bus.is_output_valid, bus.mem_req} !== 3'b0 || bus.dout !== 32'h0) begin
            failures++;
            $display("FAIL reset_in_fill rdy/ov/req=%b dout=%h exp 000/0",
                     {bus.is_ready, bus.is_output_valid, bus.mem_req}, bus.dout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // late fill pulse from the abandoned transaction
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
        @(posedge clk);
        #1 bus.mem_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.is_ready !== 1'b1 || bus.is_output_valid !== 1'b0) begin
            failures++;
            $display("FAIL late_rvalid rdy=%b ov=%b exp 1/0", bus.is_ready, bus.is_output_valid);
        end
        send(32'h10, 1'b0, 32'h0);
        wait_mem(got, we, a, wd);
        checks++;
        if (got !== 1'b1 || we !== 1'b0 || a !== 32'h10) begin
            failures++;
            $display("FAIL post_reset_miss got=%b we=%b addr=%h exp 1/0/00000010", got, we, a);
        end
        give_fill({32'h74, 32'h73, 32'h72, 32'h71});
        wait_resp(got, d, hit, cyc, sawreq);
        checks++;
        if (got !== 1'b1 || d !== 32'h71 || hit !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_resp dout=%h hit=%b exp 00000071/0", d, hit);
        end
    endtask

    initial begin
        bus.is_input_valid = 1'b0;
        bus.addr       = 32'h0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.din        = 32'h0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        test_reset();
        test_cold_load();
        test_store_hit();
        test_dirty_evict();
        test_delayed_grant();
        test_store_miss();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
